// File: rtl/data_store_buffer.sv
// Posted-write buffer between the data cache controllers and external memory:
// in-order drain over req/ack, with same-cycle load forwarding from buffered stores.
module data_store_buffer #(
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  ldu_push_i,
  input  logic [ADDR_WIDTH-1:0] ldu_address_i,
  input  logic [DATA_WIDTH-1:0] ldu_data_i,
  input  logic                  stu_push_i,
  input  logic [ADDR_WIDTH-1:0] stu_address_i,
  input  logic [DATA_WIDTH-1:0] stu_data_i,
  input  logic [1:0]            stu_width_i,
  output logic                  ldu_accept_o,
  output logic                  stu_accept_o,
  output logic                  port_idle_o,
  output logic                  full_o,
  output logic                  empty_o,
  input  logic [ADDR_WIDTH-1:0] load_address_i,
  output logic                  address_match_o,
  output logic                  partial_match_o,
  output logic [DATA_WIDTH-1:0] forward_data_o,
  output logic                  mem_request_o,
  output logic [ADDR_WIDTH-1:0] mem_address_o,
  output logic [DATA_WIDTH-1:0] mem_data_o,
  output logic [1:0]            mem_width_o,
  input  logic                  mem_acknowledge_i
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {IDLE, REQ} state_t;

  logic [ADDR_WIDTH-1:0] entry_addr  [DEPTH];
  logic [DATA_WIDTH-1:0] entry_data  [DEPTH];
  logic [1:0]            entry_width [DEPTH];
  logic [DEPTH-1:0]      entry_valid;
  logic [PW-1:0]         head;
  logic [PW-1:0]         tail;
  logic [CW-1:0]         count;
  state_t                state;

  logic                  push;
  logic                  pop;
  logic [ADDR_WIDTH-1:0] push_addr;
  logic [DATA_WIDTH-1:0] push_data;
  logic [1:0]            push_width;

  assign full_o       = (count == CW'(DEPTH));
  assign empty_o      = (count == '0);
  assign port_idle_o  = !full_o;
  assign ldu_accept_o = ldu_push_i & !full_o;
  assign stu_accept_o = stu_push_i & !full_o & !ldu_push_i;
  assign push         = ldu_accept_o | stu_accept_o;
  assign pop          = (state == REQ) & mem_acknowledge_i;

  // Writebacks from the load unit are always whole words
  assign push_addr  = ldu_push_i ? ldu_address_i : stu_address_i;
  assign push_data  = ldu_push_i ? ldu_data_i    : stu_data_i;
  assign push_width = ldu_push_i ? 2'b10         : stu_width_i;

  // Entry payload carries no reset; entry_valid and count qualify it
  always_ff @(posedge clk_i) begin
    if (push) begin
      entry_addr[tail]  <= push_addr;
      entry_data[tail]  <= push_data;
      entry_width[tail] <= push_width;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      entry_valid   <= '0;
      head          <= '0;
      tail          <= '0;
      count         <= '0;
      state         <= IDLE;
      mem_request_o <= 1'b0;
      mem_address_o <= '0;
      mem_data_o    <= '0;
      mem_width_o   <= '0;
    end else begin
      if (push) begin
        entry_valid[tail] <= 1'b1;
        tail              <= tail + 1'b1;
      end
      if (pop) begin
        entry_valid[head] <= 1'b0;
        head              <= head + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      // Drain: head is latched on entry to REQ and held until acknowledged
      case (state)
        IDLE: begin
          if (count != '0) begin
            state         <= REQ;
            mem_request_o <= 1'b1;
            mem_address_o <= entry_addr[head];
            mem_data_o    <= entry_data[head];
            mem_width_o   <= entry_width[head];
          end
        end
        REQ: begin
          if (mem_acknowledge_i) begin
            state         <= IDLE;
            mem_request_o <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic                  hit;
  logic                  hit_wide;
  logic [DATA_WIDTH-1:0] hit_data;
  logic [PW-1:0]         idx;

  // Walk oldest to youngest so the last match seen is the one closest to tail
  always_comb begin
    hit      = 1'b0;
    hit_wide = 1'b0;
    hit_data = '0;
    idx      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if (entry_valid[idx] &&
          entry_addr[idx][ADDR_WIDTH-1:2] == load_address_i[ADDR_WIDTH-1:2]) begin
        hit      = 1'b1;
        hit_wide = entry_width[idx][1];
        hit_data = entry_data[idx];
      end
    end
    address_match_o = hit & hit_wide;
    partial_match_o = hit & !hit_wide;
    forward_data_o  = hit ? hit_data : '0;
  end

endmodule

// File: tb/tb_data_store_buffer.sv
// Self-checking bench for data_store_buffer: scoreboard of accepted pushes
// compared against each memory write, plus flag and forwarding checks.
module tb_data_store_buffer;

  localparam int DEPTH = 4;
  localparam int AW    = 32;
  localparam int DW    = 32;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          ldu_push_i = 1'b0;
  logic [AW-1:0] ldu_address_i = '0;
  logic [DW-1:0] ldu_data_i = '0;
  logic          stu_push_i = 1'b0;
  logic [AW-1:0] stu_address_i = '0;
  logic [DW-1:0] stu_data_i = '0;
  logic [1:0]    stu_width_i = 2'b10;
  logic          ldu_accept_o, stu_accept_o, port_idle_o, full_o, empty_o;
  logic [AW-1:0] load_address_i = '0;
  logic          address_match_o, partial_match_o;
  logic [DW-1:0] forward_data_o;
  logic          mem_request_o;
  logic [AW-1:0] mem_address_o;
  logic [DW-1:0] mem_data_o;
  logic [1:0]    mem_width_o;
  logic          mem_acknowledge_i = 1'b0;

  data_store_buffer #(.DEPTH(DEPTH), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .ldu_push_i(ldu_push_i), .ldu_address_i(ldu_address_i), .ldu_data_i(ldu_data_i),
    .stu_push_i(stu_push_i), .stu_address_i(stu_address_i), .stu_data_i(stu_data_i),
    .stu_width_i(stu_width_i),
    .ldu_accept_o(ldu_accept_o), .stu_accept_o(stu_accept_o),
    .port_idle_o(port_idle_o), .full_o(full_o), .empty_o(empty_o),
    .load_address_i(load_address_i), .address_match_o(address_match_o),
    .partial_match_o(partial_match_o), .forward_data_o(forward_data_o),
    .mem_request_o(mem_request_o), .mem_address_o(mem_address_o),
    .mem_data_o(mem_data_o), .mem_width_o(mem_width_o),
    .mem_acknowledge_i(mem_acknowledge_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [1:0]    width;
  } entry_t;

  entry_t sb[$];
  int     n_checks = 0;
  int     n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push_stu(input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic [1:0] w, output logic acc);
    stu_push_i = 1'b1; stu_address_i = a; stu_data_i = d; stu_width_i = w;
    #1;
    acc = stu_accept_o;
    if (acc) sb.push_back('{addr: a, data: d, width: w});
    tick();
    stu_push_i = 1'b0;
  endtask

  task automatic drain_one(input int hold);
    entry_t e;
    int n = 0;
    while (!mem_request_o && n < 20) begin
      tick();
      n++;
    end
    if (!mem_request_o) begin
      chk("req_timeout", 0, 1);
      return;
    end
    if (sb.size() == 0) begin
      chk("unexpected_req", 1, 0);
      return;
    end
    e = sb[0];
    chk("mem_addr", mem_address_o, e.addr);
    chk("mem_data", mem_data_o, e.data);
    chk("mem_width", mem_width_o, e.width);
    for (int i = 0; i < hold; i++) begin
      tick();
      chk("req_held", mem_request_o, 1);
      chk("addr_stable", mem_address_o, e.addr);
      chk("data_stable", mem_data_o, e.data);
    end
    mem_acknowledge_i = 1'b1;
    tick();
    mem_acknowledge_i = 1'b0;
    void'(sb.pop_front());
  endtask

  logic acc;

  initial begin
    // Reset and idle
    repeat (2) tick();
    rst_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("idle_empty", empty_o, 1);
      chk("idle_full", full_o, 0);
      chk("idle_port", port_idle_o, 1);
      chk("idle_req", mem_request_o, 0);
      chk("idle_maddr", mem_address_o, 0);
      tick();
    end

    // Single store: request latency, stability, empty after ack
    push_stu(32'h1000, 32'hDEADBEEF, 2'b10, acc);
    chk("single_acc", acc, 1);
    chk("req_not_yet", mem_request_o, 0);
    tick();
    chk("req_rise", mem_request_o, 1);
    drain_one(3);
    chk("empty_after_ack", empty_o, 1);
    chk("req_low_after_ack", mem_request_o, 0);

    // Fill to full, reject, free one slot, accept
    for (int i = 0; i < DEPTH; i++) begin
      push_stu(32'h100 + 32'(i * 4), 32'hC0DE0000 + 32'(i), 2'b10, acc);
      chk("fill_acc", acc, 1);
    end
    chk("full_set", full_o, 1);
    chk("port_busy", port_idle_o, 0);
    push_stu(32'h200, 32'h12345678, 2'b10, acc);
    chk("full_reject", acc, 0);
    drain_one(0);
    chk("full_clear", full_o, 0);
    push_stu(32'h204, 32'h87654321, 2'b11, acc);
    chk("refill_acc", acc, 1);
    while (sb.size() != 0) drain_one(0);

    // Forwarding: youngest word, then youngest byte, then miss
    push_stu(32'h2000, 32'hAAAA0000, 2'b10, acc);
    push_stu(32'h2000, 32'hBBBB1111, 2'b10, acc);
    load_address_i = 32'h2002;
    #1;
    chk("fwd_match", address_match_o, 1);
    chk("fwd_partial0", partial_match_o, 0);
    chk("fwd_data", forward_data_o, 32'hBBBB1111);
    push_stu(32'h2001, 32'h00000055, 2'b00, acc);
    chk("byte_match0", address_match_o, 0);
    chk("byte_partial", partial_match_o, 1);
    load_address_i = 32'h5000;
    #1;
    chk("miss_match", address_match_o, 0);
    chk("miss_partial", partial_match_o, 0);
    chk("miss_data", forward_data_o, 0);
    while (sb.size() != 0) drain_one(1);

    // Simultaneous ldu and stu push: ldu wins, stu retries
    ldu_push_i = 1'b1; ldu_address_i = 32'h3000; ldu_data_i = 32'h33333333;
    stu_push_i = 1'b1; stu_address_i = 32'h4000; stu_data_i = 32'h44444444; stu_width_i = 2'b10;
    #1;
    chk("both_ldu_acc", ldu_accept_o, 1);
    chk("both_stu_acc", stu_accept_o, 0);
    if (ldu_accept_o) sb.push_back('{addr: 32'h3000, data: 32'h33333333, width: 2'b10});
    tick();
    ldu_push_i = 1'b0;
    #1;
    chk("retry_stu_acc", stu_accept_o, 1);
    if (stu_accept_o) sb.push_back('{addr: 32'h4000, data: 32'h44444444, width: 2'b10});
    tick();
    stu_push_i = 1'b0;
    drain_one(0);
    drain_one(0);
    chk("order_empty", empty_o, 1);

    // Reset during an outstanding write
    for (int i = 0; i < 3; i++) push_stu(32'h6000 + 32'(i * 4), 32'(i), 2'b10, acc);
    chk("pre_rst_req", mem_request_o, 1);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    chk("rst_req", mem_request_o, 0);
    chk("rst_empty", empty_o, 1);
    sb.delete();
    mem_acknowledge_i = 1'b1;
    tick();
    mem_acknowledge_i = 1'b0;
    chk("late_ack_empty", empty_o, 1);
    chk("late_ack_req", mem_request_o, 0);
    tick();
    chk("late_ack_empty2", empty_o, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/data_store_buffer.md
Name: data_store_buffer

Overview:
- Posted-write buffer directly downstream of the data cache controllers.
- Accepts word writebacks from the load-unit cache controller (dirty-line eviction) and write-through stores from the store-unit cache controller.
- Drains entries in order to external memory over a request/acknowledge handshake.
- Provides same-cycle load forwarding (address match + data) back to the load controller.

Parameters:
DEPTH, 4, number of entries (power of two, >= 2)
ADDR_WIDTH, 32, byte address width
DATA_WIDTH, 32, data word width

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, synchronous, active-high
ldu_push_i  in  1  load-unit writeback push request
ldu_address_i  in  ADDR_WIDTH  writeback byte address
ldu_data_i  in  DATA_WIDTH  writeback word
stu_push_i  in  1  store-unit push request
stu_address_i  in  ADDR_WIDTH  store byte address
stu_data_i  in  DATA_WIDTH  store data, right-aligned
stu_width_i  in  2  00 byte, 01 half, 10 word, 11 treated as word
ldu_accept_o  out  1  ldu push accepted this cycle
stu_accept_o  out  1  stu push accepted this cycle
port_idle_o  out  1  buffer can accept a push (not full)
full_o  out  1  count == DEPTH
empty_o  out  1  count == 0
load_address_i  in  ADDR_WIDTH  load byte address for forwarding
address_match_o  out  1  youngest matching entry is full-word: forwarding valid
partial_match_o  out  1  youngest matching entry is byte/half: load must wait
forward_data_o  out  DATA_WIDTH  data of youngest matching entry
mem_request_o  out  1  external write request
mem_address_o  out  ADDR_WIDTH  head entry address
mem_data_o  out  DATA_WIDTH  head entry data
mem_width_o  out  2  head entry width
mem_acknowledge_i  in  1  external write done

Behaviour:

Reset:
- rst_i high at a clock edge: all entries invalid, head = tail = count = 0, FSM = IDLE.
- Outputs after reset: mem_request_o 0, mem_address/data/width 0, empty_o 1, full_o 0, port_idle_o 1, match outputs 0.
- Reset mid-transaction abandons the in-flight write; mem_request_o is 0 the cycle after reset.

Storage and flags:
- Circular FIFO of {address, data, width, valid}.
- Pointers wrap modulo DEPTH.
- full_o and empty_o derive from the registered count.

Push:
- Accept is combinational: ldu_accept_o = ldu_push_i & !full_o.
- Priority: stu_accept_o = stu_push_i & !full_o & !ldu_push_i. Ldu always wins a simultaneous push; the store unit must hold its request.
- An ldu entry is stored with width 10.
- One entry is written per cycle at tail; tail++ and count++ at the edge.
- Push into a full buffer is rejected even if a pop occurs the same cycle.

Drain FSM, states IDLE and REQ:
- IDLE: if count != 0, go to REQ next cycle.
- REQ: mem_request_o = 1. mem_address/data/width are registered from head on entry to REQ and held stable until acknowledge.
- REQ with mem_acknowledge_i = 1: pop head (valid cleared, head++, count--), return to IDLE.
- mem_request_o is therefore low for at least one cycle between transactions. Peak drain rate is one entry every 2 cycles.
- mem_acknowledge_i is ignored in IDLE.

Simultaneous push and pop:
- Count unchanged; both pointers advance.

Forwarding (combinational):
- Compare load_address_i[ADDR_WIDTH-1:2] against all valid entries, including the entry currently being drained.
- Select the youngest match (closest to tail).
- Youngest match width 10/11: address_match_o = 1, forward_data_o = its data.
- Youngest match width 00/01: partial_match_o = 1, address_match_o = 0.
- No match: both 0, forward_data_o = 0.
- Same-cycle pushes are not visible to forwarding.

Test Plan:
- Reset then idle 5 cycles -> empty_o 1, full_o 0, port_idle_o 1, mem_request_o 0 throughout.
- stu push word 0x1000/0xDEADBEEF, acknowledge held 3 cycles after request rises:
  - mem_request_o rises 2 cycles after push with addr 0x1000, data 0xDEADBEEF, width 10, all stable until acknowledge.
  - empty_o 1 the cycle after acknowledge.
- 4 stu pushes with acknowledge held low:
  - full_o 1 and port_idle_o 0; 5th push gives stu_accept_o 0.
  - After one acknowledge, full_o 0 and the next push is accepted.
- Forwarding:
  - Push word 0x2000=0xAAAA0000 then 0x2000=0xBBBB1111; load 0x2002 -> address_match_o 1, forward_data_o 0xBBBB1111.
  - Then push byte 0x2001 -> address_match_o 0, partial_match_o 1.
- ldu (0x3000) and stu (0x4000) push in the same cycle with buffer empty:
  - ldu_accept_o 1, stu_accept_o 0; stu retries and is accepted next cycle.
  - Drain order 0x3000 then 0x4000.
- rst_i asserted while mem_request_o = 1 with 3 entries:
  - Next cycle mem_request_o 0, empty_o 1.
  - A late acknowledge is ignored and count stays 0.
